// File: rtl/smg_scan_decoder.sv
`timescale 1ns / 1ps
// Purpose : readback decoder for the 6-digit active-low multiplexed 7-seg bus; rebuilds whole frames.
// Latency : 2-cycle input sync + SETTLE_CYC dwell to capture; frame_valid 8 cycles after the completing capture.
// Backpr. : none; the bus is free-running and captures continue while a frame is being accumulated.
module smg_scan_decoder #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [5:0]  smg_wei_in,
  input  logic [7:0]  smg_duan_in,
  output logic        frame_valid,
  output logic [19:0] data_out,
  output logic [5:0]  point_out,
  output logic        sign_out,
  output logic        en_out,
  output logic        frame_err,
  output logic [23:0] digits_out
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // The settle counter saturates one below SETTLE_CYC; capture fires on the step into that value.
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] SETTLE_CAP = SW'(SETTLE_CYC - 2);

  // The idle counter saturates at TIMEOUT_CYC so the timeout fires once per blank stretch.
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYC);

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_MINUS = 4'hB;
  localparam logic [3:0] CODE_BAD   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_t;

  // Synchronizer stages and previous-cycle copies of the bus.
  logic [5:0]    wei_meta;
  logic [5:0]    wei_sync;
  logic [7:0]    duan_meta;
  logic [7:0]    duan_sync;
  logic [5:0]    wei_prev;
  logic [7:0]    duan_prev;

  // Dwell qualification.
  logic [2:0]    pos;
  logic          pos_vld;
  logic          stable;
  logic [SW-1:0] settle_cnt;
  logic          cap_fire;
  logic [5:0]    cap_bit;

  // Pattern decode of the current segments.
  logic [3:0]    seg_code;
  logic          seg_dp;

  // Display-off detection.
  logic          all_off;
  logic [TW-1:0] idle_cnt;
  logic          timeout_fire;

  // Capture storage and frame mask.
  logic [23:0]   cap_codes;
  logic [5:0]    cap_dp;
  logic [5:0]    mask;

  // Frame assembly.
  state_t        state;
  logic          snap;
  logic [23:0]   work_codes;
  logic [5:0]    work_dp;
  logic [19:0]   acc;
  logic [2:0]    acc_idx;
  logic [3:0]    acc_code;
  logic [19:0]   acc_val;
  logic          has_minus;
  logic          has_bad;

  // Two-flop synchronizers; reset to the idle bus level (all lines high).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wei_meta  <= 6'h3F;
      wei_sync  <= 6'h3F;
      duan_meta <= 8'hFF;
      duan_sync <= 8'hFF;
    end else begin
      wei_meta  <= smg_wei_in;
      wei_sync  <= wei_meta;
      duan_meta <= smg_duan_in;
      duan_sync <= duan_meta;
    end
  end

  // Remember last cycle's bus so any change restarts the dwell.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wei_prev  <= 6'h3F;
      duan_prev <= 8'hFF;
    end else begin
      wei_prev  <= wei_sync;
      duan_prev <= duan_sync;
    end
  end

  // Map a single low select line to its position; anything else is not a valid dwell.
  always_comb begin
    pos     = 3'd0;
    pos_vld = 1'b1;
    case (wei_sync)
      6'b011111: pos = 3'd0;
      6'b101111: pos = 3'd1;
      6'b110111: pos = 3'd2;
      6'b111011: pos = 3'd3;
      6'b111101: pos = 3'd4;
      6'b111110: pos = 3'd5;
      default:   pos_vld = 1'b0;
    endcase
  end

  assign stable   = pos_vld && (wei_sync == wei_prev) && (duan_sync == duan_prev);
  assign cap_fire = stable && (settle_cnt == SETTLE_CAP);
  assign cap_bit  = cap_fire ? (6'd1 << pos) : 6'd0;

  // Dwell counter: restarts on any bus change, saturates so each dwell captures only once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      settle_cnt <= '0;
    end else if (!stable) begin
      settle_cnt <= '0;
    end else if (settle_cnt != SETTLE_MAX) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // Common-anode segment table; an all-dark bus is a blank digit and never carries a point.
  always_comb begin
    case (duan_sync[6:0])
      7'b1000000: seg_code = 4'd0;
      7'b1111001: seg_code = 4'd1;
      7'b0100100: seg_code = 4'd2;
      7'b0110000: seg_code = 4'd3;
      7'b0011001: seg_code = 4'd4;
      7'b0010010: seg_code = 4'd5;
      7'b0000010: seg_code = 4'd6;
      7'b1111000: seg_code = 4'd7;
      7'b0000000: seg_code = 4'd8;
      7'b0010000: seg_code = 4'd9;
      7'b0111111: seg_code = CODE_MINUS;
      default:    seg_code = CODE_BAD;
    endcase
    seg_dp = ~duan_sync[7];
    if (duan_sync == 8'hFF) begin
      seg_code = CODE_BLANK;
      seg_dp   = 1'b0;
    end
  end

  assign all_off      = (wei_sync == 6'h3F);
  assign timeout_fire = all_off && (idle_cnt == TIMEOUT_LAST);

  // Count consecutive all-off cycles; multi-select patterns are not "off" and restart the count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt <= '0;
    end else if (!all_off) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TIMEOUT_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Display-active flag: raised by any capture, dropped when the bus has been dark too long.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_out <= 1'b0;
    end else if (timeout_fire) begin
      en_out <= 1'b0;
    end else if (cap_fire) begin
      en_out <= 1'b1;
    end
  end

  // Per-position capture store; a recapture simply overwrites the earlier value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cap_codes <= '0;
      cap_dp    <= '0;
    end else if (cap_fire) begin
      cap_codes[{pos, 2'b00} +: 4] <= seg_code;
      cap_dp[pos]                  <= seg_dp;
    end
  end

  // Frame mask: cleared on snapshot or timeout, but a capture landing on the same edge is kept.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mask <= '0;
    end else if (snap || timeout_fire) begin
      mask <= cap_bit;
    end else begin
      mask <= mask | cap_bit;
    end
  end

  assign snap     = (state == ST_IDLE) && (mask == 6'h3F);
  assign acc_code = work_codes[{acc_idx, 2'b00} +: 4];
  assign acc_val  = (acc_code <= 4'd9) ? {16'd0, acc_code} : 20'd0;

  // Frame-wide flags taken from the snapshot while it is being accumulated.
  always_comb begin
    has_minus = 1'b0;
    has_bad   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (work_codes[i*4 +: 4] == CODE_MINUS) has_minus = 1'b1;
      if (work_codes[i*4 +: 4] == CODE_BAD)   has_bad   = 1'b1;
    end
  end

  // Frame FSM: snapshot the completed mask, fold digits most-significant first, publish once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      work_codes  <= '0;
      work_dp     <= '0;
      acc         <= '0;
      acc_idx     <= '0;
      frame_valid <= 1'b0;
      data_out    <= '0;
      point_out   <= '0;
      sign_out    <= 1'b0;
      frame_err   <= 1'b0;
      digits_out  <= '0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (snap) begin
            work_codes <= cap_codes;
            work_dp    <= cap_dp;
            acc        <= '0;
            acc_idx    <= 3'd5;
            state      <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc <= acc * 20'd10 + acc_val;
          if (acc_idx == 3'd0) begin
            state <= ST_DONE;
          end else begin
            acc_idx <= acc_idx - 3'd1;
          end
        end
        ST_DONE: begin
          data_out    <= acc;
          point_out   <= work_dp;
          digits_out  <= work_codes;
          sign_out    <= has_minus;
          frame_err   <= has_bad;
          frame_valid <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smg_scan_decoder.sv
`timescale 1ns / 1ps
// Purpose : directed scans of the multiplexed display bus with a frame scoreboard.
// Latency : expected frames are queued at issue time and popped when frame_valid is seen.
// Backpr. : none; any frame_valid with an empty queue is an unexpected frame.
module tb_smg_scan_decoder;

  localparam int SETTLE = 16;
  localparam int TMO    = 200;
  localparam int DWELL  = 24;
  localparam int GAP    = 30;

  localparam logic [7:0] D0 = 8'hC0, D1 = 8'hF9, D2 = 8'hA4, D3 = 8'hB0, D4 = 8'h99;
  localparam logic [7:0] D5 = 8'h92, D6 = 8'h82, D7 = 8'hF8, D8 = 8'h80, D9 = 8'h90;
  localparam logic [7:0] DBL = 8'hFF, DMI = 8'hBF, DBAD = 8'hD5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [5:0]  wei = 6'h3F;
  logic [7:0]  duan = 8'hFF;
  logic        frame_valid;
  logic [19:0] data_out;
  logic [5:0]  point_out;
  logic        sign_out;
  logic        en_out;
  logic        frame_err;
  logic [23:0] digits_out;

  typedef struct packed {
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        err;
    logic [23:0] digits;
  } frame_t;

  frame_t exp_q[$];
  int total = 0;
  int bad   = 0;

  always #10 sys_clk = ~sys_clk;

  smg_scan_decoder #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .smg_wei_in (wei),
    .smg_duan_in(duan),
    .frame_valid(frame_valid),
    .data_out   (data_out),
    .point_out  (point_out),
    .sign_out   (sign_out),
    .en_out     (en_out),
    .frame_err  (frame_err),
    .digits_out (digits_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [19:0] d, input logic [5:0] p, input logic s,
                      input logic e, input logic [23:0] dg);
    frame_t f;
    f.data   = d;
    f.point  = p;
    f.sign   = s;
    f.err    = e;
    f.digits = dg;
    exp_q.push_back(f);
  endtask

  // Drive one digit right after a falling edge and hold it for n cycles.
  task automatic show(input int pos, input logic [7:0] d, input int n);
    wei  = ~(6'd1 << (5 - pos));
    duan = d;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic off(input int n);
    wei  = 6'h3F;
    duan = 8'hFF;
    repeat (n) @(negedge sys_clk);
  endtask

  // v holds the six segment bytes, position 5 in the top byte.
  task automatic scan(input logic [47:0] v);
    for (int p = 5; p >= 0; p--) show(p, v[p*8 +: 8], DWELL);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_fv"},     32'(frame_valid), 32'd0);
    check({tag, "_data"},   32'(data_out),    32'd0);
    check({tag, "_point"},  32'(point_out),   32'd0);
    check({tag, "_sign"},   32'(sign_out),    32'd0);
    check({tag, "_en"},     32'(en_out),      32'd0);
    check({tag, "_err"},    32'(frame_err),   32'd0);
    check({tag, "_digits"}, 32'(digits_out),  32'd0);
  endtask

  // Scoreboard monitor: every frame_valid must match the oldest queued expectation.
  initial begin : monitor
    frame_t e;
    forever begin
      @(negedge sys_clk);
      if (frame_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got frame_valid with data_out=%0h digits_out=%0h expected no frame",
                   data_out, digits_out);
        end else begin
          e = exp_q.pop_front();
          check("frame_data",   32'(data_out),   32'(e.data));
          check("frame_point",  32'(point_out),  32'(e.point));
          check("frame_sign",   32'(sign_out),   32'(e.sign));
          check("frame_err",    32'(frame_err),  32'(e.err));
          check("frame_digits", 32'(digits_out), 32'(e.digits));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    check_outputs_zero("reset");
    sys_rst_n = 1'b1;
    off(5);

    // 123456, no points; also pins the 8-cycle capture-to-frame latency.
    push(20'h1E240, 6'b000000, 1'b0, 1'b0, 24'h123456);
    show(5, D1, DWELL); show(4, D2, DWELL); show(3, D3, DWELL);
    show(2, D4, DWELL); show(1, D5, DWELL);
    show(0, D6, SETTLE + 2 + 7);
    check("latency_early", 32'(frame_valid), 32'd0);
    @(negedge sys_clk);
    check("latency_pulse", 32'(frame_valid), 32'd1);
    check("en_after_scan", 32'(en_out), 32'd1);
    off(GAP);

    // Blanks, minus, and a lit point on position 1.
    push(20'd42, 6'b000010, 1'b1, 1'b0, 24'hAAAB42);
    scan({DBL, DBL, DBL, DMI, D4 & 8'h7F, D2});
    off(GAP);

    // Too-short dwell on position 0 must not capture; the mask survives until a real capture.
    show(5, D9, DWELL); show(4, D8, DWELL); show(3, D7, DWELL);
    show(2, D6, DWELL); show(1, D5, DWELL);
    show(0, D1, SETTLE - 2);
    off(40);
    push(20'hF1202, 6'b000000, 1'b0, 1'b0, 24'h987650);
    show(0, D0, DWELL);
    off(GAP);

    // Undecodable pattern on position 2 weighs zero and flags the frame.
    push(20'h1E0B0, 6'b000000, 1'b0, 1'b1, 24'h123F56);
    scan({D1, D2, D3, DBAD, D5, D6});
    off(GAP);

    // Timeout boundary, then the partial mask must have been discarded.
    check("en_before_timeout", 32'(en_out), 32'd1);
    show(5, D7, DWELL); show(4, D7, DWELL); show(3, D7, DWELL);
    wei  = 6'h3F;
    duan = 8'hFF;
    repeat (TMO + 1) @(negedge sys_clk);
    check("en_one_short", 32'(en_out), 32'd1);
    @(negedge sys_clk);
    check("en_timeout", 32'(en_out), 32'd0);
    show(2, D1, DWELL); show(1, D2, DWELL); show(0, D3, DWELL);
    check("en_recapture", 32'(en_out), 32'd1);
    off(GAP);
    push(20'h9FB2B, 6'b000000, 1'b0, 1'b0, 24'h654123);
    show(5, D6, DWELL); show(4, D5, DWELL); show(3, D4, DWELL);
    off(GAP);

    // Two selects low for a long time: no capture and no progress toward timeout.
    show(5, D3, DWELL); show(4, D3, DWELL); show(3, D3, DWELL);
    show(2, D3, DWELL); show(1, D3, DWELL);
    wei  = 6'b001111;
    duan = D8;
    repeat (1000) @(negedge sys_clk);
    check("en_multi_select", 32'(en_out), 32'd1);
    push(20'h5161A, 6'b000000, 1'b0, 1'b0, 24'h333338);
    show(0, D8, DWELL);
    off(GAP);

    // Reset while the frame is being accumulated: nothing may be published.
    show(5, D5, DWELL); show(4, D5, DWELL); show(3, D5, DWELL);
    show(2, D5, DWELL); show(1, D5, DWELL);
    show(0, D5, SETTLE + 2 + 4);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_outputs_zero("mid_acc_reset");
    wei  = 6'h3F;
    duan = 8'hFF;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    off(60);

    check("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
